// File: rtl/tsc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tsc_monitor
// Brief    : Passive runtime monitor for the AES trigger path. Counts r1&r2
//            coincidences per observation window and trigger rising edges,
//            and raises a sticky, acknowledgeable alarm.
// Revision : 1.0 - initial release
// ============================================================================
module tsc_monitor #(
  parameter int CNT_W        = 8,
  parameter int WINDOW       = 256,
  parameter int COINC_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r1,
  input  logic             r2,
  input  logic             trigger,
  input  logic             ack,
  output logic             alarm,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] coinc_cnt,
  output logic [7:0]       total_trig,
  output logic [1:0]       state
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(COINC_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WATCH = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;

  logic             r1_q;
  logic             r2_q;
  logic             trig_q;
  logic             trig_qq;
  logic [WIN_W-1:0] win_cnt;

  logic             coinc;
  logic             trig_rise;
  logic             wrap;
  logic             thr_hit;
  logic             alarm_event;
  logic [1:0]       event_bits;
  logic             ack_clear;
  logic [CNT_W-1:0] coinc_next;
  logic [WIN_W-1:0] win_next;

  // Sample stage: one register on every monitored input, plus a second
  // trigger stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      trig_q  <= 1'b0;
      trig_qq <= 1'b0;
    end else begin
      r1_q    <= r1;
      r2_q    <= r2;
      trig_q  <= trigger;
      trig_qq <= trig_q;
    end
  end

  // Derived events, next counter values and the threshold crossing.
  always_comb begin
    coinc     = r1_q & r2_q;
    trig_rise = trig_q & ~trig_qq;
    wrap      = (win_cnt == WIN_LAST);
    win_next  = wrap ? '0 : win_cnt + WIN_W'(1);

    // A coincidence on the wrap cycle opens the new window's count.
    if (wrap) begin
      coinc_next = {{(CNT_W-1){1'b0}}, coinc};
    end else if (coinc && (coinc_cnt != CNT_MAX)) begin
      coinc_next = coinc_cnt + CNT_W'(1);
    end else begin
      coinc_next = coinc_cnt;
    end

    // Only a counting step can cross the threshold; a saturated counter
    // that merely holds its value does not re-fire.
    thr_hit     = coinc && (coinc_next == THRESH) &&
                  (wrap || (coinc_cnt != CNT_MAX));
    event_bits  = {trig_rise, thr_hit};
    alarm_event = trig_rise | thr_hit;
    ack_clear   = (state == ALARM) && ack;
  end

  // Window and coincidence counters; an acknowledge in ALARM restarts both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt   <= '0;
      coinc_cnt <= '0;
    end else if (ack_clear) begin
      win_cnt   <= '0;
      coinc_cnt <= '0;
    end else begin
      win_cnt   <= win_next;
      coinc_cnt <= coinc_next;
    end
  end

  // Saturating count of trigger rising edges; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      total_trig <= 8'd0;
    end else if (trig_rise && (total_trig != 8'hFF)) begin
      total_trig <= total_trig + 8'd1;
    end
  end

  // Monitor FSM and alarm cause capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cause <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_event) begin
            state <= ALARM;
            cause <= event_bits;
          end else if (coinc) begin
            state <= WATCH;
          end
        end
        WATCH: begin
          if (alarm_event) begin
            state <= ALARM;
            cause <= event_bits;
          end else if (wrap && !coinc) begin
            state <= IDLE;
          end
        end
        ALARM: begin
          if (ack) begin
            // A fresh event beats the acknowledge and replaces stale bits.
            if (alarm_event) begin
              cause <= event_bits;
            end else begin
              state <= IDLE;
              cause <= 2'b00;
            end
          end else begin
            cause <= cause | event_bits;
          end
        end
        default: begin
          state <= IDLE;
          cause <= 2'b00;
        end
      endcase
    end
  end

  assign alarm = (state == ALARM);

endmodule
`default_nettype wire

// File: tb/tb_tsc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsc_monitor
// Brief    : Directed self-checking bench for tsc_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsc_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r1 = 1'b0, r2 = 1'b0, trigger = 1'b0, ack = 1'b0;
  logic       alarm;
  logic [1:0] cause;
  logic [7:0] coinc_cnt;
  logic [7:0] total_trig;
  logic [1:0] state;

  logic       r1b = 1'b0, r2b = 1'b0, trigb = 1'b0, ackb = 1'b0;
  logic       alarm_b;
  logic [1:0] cause_b;
  logic [3:0] coinc_cnt_b;
  logic [7:0] total_trig_b;
  logic [1:0] state_b;

  int checks = 0;
  int errors = 0;

  tsc_monitor #(.CNT_W(8), .WINDOW(16), .COINC_THRESH(4)) dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .trigger(trigger), .ack(ack),
    .alarm(alarm), .cause(cause), .coinc_cnt(coinc_cnt),
    .total_trig(total_trig), .state(state)
  );

  tsc_monitor #(.CNT_W(4), .WINDOW(64), .COINC_THRESH(15)) dut_sat (
    .clk(clk), .rst(rst), .r1(r1b), .r2(r2b), .trigger(trigb), .ack(ackb),
    .alarm(alarm_b), .cause(cause_b), .coinc_cnt(coinc_cnt_b),
    .total_trig(total_trig_b), .state(state_b)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_coinc();
    r1 = 1'b1; r2 = 1'b1;
    tick();
    r1 = 1'b0; r2 = 1'b0;
    tick();
  endtask

  initial begin
    // Reset with every monitored input high
    rst = 1'b0; r1 = 1'b1; r2 = 1'b1; trigger = 1'b1;
    tick();
    check("rst_alarm_c1", 32'(alarm), 0);
    tick(2);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_cause", 32'(cause), 0);
    check("rst_coinc", 32'(coinc_cnt), 0);
    check("rst_total", 32'(total_trig), 0);
    check("rst_state", 32'(state), 0);

    // Release with trigger still high: one rise, alarm two cycles later
    rst = 1'b1; r1 = 1'b0; r2 = 1'b0;
    tick();
    check("rel_alarm_c1", 32'(alarm), 0);
    check("rel_total_c1", 32'(total_trig), 0);
    tick();
    check("rel_alarm_c2", 32'(alarm), 1);
    check("rel_cause_c2", 32'(cause), 2);
    check("rel_total_c2", 32'(total_trig), 1);
    check("rel_state_c2", 32'(state), 2);
    tick();
    check("rel_total_c3", 32'(total_trig), 1);

    // Plain acknowledge; window restarts at 0
    ack = 1'b1; trigger = 1'b0;
    tick();
    ack = 1'b0;
    check("ack_alarm", 32'(alarm), 0);
    check("ack_state", 32'(state), 0);
    check("ack_cause", 32'(cause), 0);

    // Threshold: four coincidences spaced two apart
    for (int i = 0; i < 4; i++) begin
      r1 = 1'b1; r2 = 1'b1;
      tick();
      r1 = 1'b0; r2 = 1'b0;
      if (i == 3) check("thr_alarm_early", 32'(alarm), 0);
      tick();
      if (i == 1) begin
        check("thr_cnt2", 32'(coinc_cnt), 2);
        check("thr_state_watch", 32'(state), 1);
      end
    end
    check("thr_alarm", 32'(alarm), 1);
    check("thr_cause", 32'(cause), 1);
    check("thr_cnt", 32'(coinc_cnt), 4);
    check("thr_state", 32'(state), 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("thr_ack_state", 32'(state), 0);
    check("thr_ack_cnt", 32'(coinc_cnt), 0);

    // Window wrap: 3, idle across the wrap, then 3 more
    for (int i = 0; i < 3; i++) pulse_coinc();
    check("wrap_cnt_a", 32'(coinc_cnt), 3);
    check("wrap_state_a", 32'(state), 1);
    tick(9);
    check("wrap_cnt_pre", 32'(coinc_cnt), 3);
    tick();
    check("wrap_cnt_post", 32'(coinc_cnt), 0);
    check("wrap_state_post", 32'(state), 0);
    for (int i = 0; i < 3; i++) pulse_coinc();
    check("wrap_cnt_b", 32'(coinc_cnt), 3);
    check("wrap_alarm", 32'(alarm), 0);

    // Trigger held high: one edge counted, not the level
    trigger = 1'b1;
    tick(2);
    check("lvl_alarm", 32'(alarm), 1);
    check("lvl_cause", 32'(cause), 2);
    check("lvl_total", 32'(total_trig), 2);
    tick(3);
    check("lvl_total_held", 32'(total_trig), 2);
    check("lvl_cnt_held", 32'(coinc_cnt), 3);

    // Ack collides with the 4th coincidence of the window
    r1 = 1'b1; r2 = 1'b1;
    tick();
    check("col_cause_pre", 32'(cause), 2);
    r1 = 1'b0; r2 = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("col_alarm", 32'(alarm), 1);
    check("col_cause", 32'(cause), 1);
    check("col_cnt", 32'(coinc_cnt), 0);
    check("col_state", 32'(state), 2);
    trigger = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("col_ack_alarm", 32'(alarm), 0);
    check("col_ack_cause", 32'(cause), 0);

    // Ack outside ALARM leaves counters and state untouched
    pulse_coinc();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_cnt", 32'(coinc_cnt), 1);
    check("idle_ack_state", 32'(state), 1);

    // 300 trigger pulses saturate total_trig
    for (int i = 0; i < 300; i++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      if (i == 252) check("sat_total_reach", 32'(total_trig), 255);
    end
    tick(2);
    check("sat_total", 32'(total_trig), 255);
    check("sat_alarm", 32'(alarm), 1);
    check("sat_cause", 32'(cause), 2);

    // Reset mid-alarm discards everything
    rst = 1'b0;
    tick();
    check("mid_rst_alarm", 32'(alarm), 0);
    check("mid_rst_cause", 32'(cause), 0);
    check("mid_rst_total", 32'(total_trig), 0);
    check("mid_rst_cnt", 32'(coinc_cnt), 0);
    check("mid_rst_state", 32'(state), 0);
    rst = 1'b1;

    // Coincidence counter saturation with threshold at all-ones
    r1b = 1'b1; r2b = 1'b1;
    tick(15);
    check("csat_cnt14", 32'(coinc_cnt_b), 14);
    check("csat_alarm_early", 32'(alarm_b), 0);
    tick();
    check("csat_cnt15", 32'(coinc_cnt_b), 15);
    check("csat_alarm", 32'(alarm_b), 1);
    check("csat_cause", 32'(cause_b), 1);
    tick(14);
    check("csat_cnt_hold", 32'(coinc_cnt_b), 15);
    check("csat_cause_hold", 32'(cause_b), 1);
    check("csat_state", 32'(state_b), 2);
    r1b = 1'b0; r2b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tsc_monitor.md
# tsc_monitor

Runtime monitor for the trigger side of the AES benchmark. It watches the same rare-event inputs (`r1`, `r2`) and the `trigger` line that the trigger-generation logic drives. It counts `r1 && r2` coincidences inside a fixed observation window and counts `trigger` rising edges. It raises a sticky, acknowledgeable alarm when either the coincidence count reaches a threshold within one window or `trigger` is seen to rise. It sits beside the AES core as a passive observer and never drives the monitored signals.

## Interface
- `CNT_W`, 8: width of the coincidence counter; legal 4..16.
- `WINDOW`, 256: observation window length in cycles; legal 2..65536.
- `COINC_THRESH`, 16: coincidences per window that raise an alarm; legal 1..2^CNT_W-1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `r1`  in  1  monitored rare-event input.
- `r2`  in  1  monitored rare-event input.
- `trigger`  in  1  monitored trigger line.
- `ack`  in  1  alarm acknowledge; single-cycle pulse or level.
- `alarm`  out  1  sticky alarm flag.
- `cause`  out  2  alarm cause: bit0 = coincidence threshold reached, bit1 = trigger rise seen.
- `coinc_cnt`  out  CNT_W  coincidences counted in the current window, saturating at all-ones.
- `total_trig`  out  8  trigger rising edges since reset, saturating at 255.
- `state`  out  2  FSM state: 0 = IDLE, 1 = WATCH, 2 = ALARM.

## Operation
- **Sample stage.** `r1`, `r2` and `trigger` are registered once into `r1_q`, `r2_q` and `trig_q`. `trig_qq` is a second register on `trig_q`.
- **Derived events.** `coinc = r1_q & r2_q`. `trig_rise = trig_q & ~trig_qq`.
- **Window counter.** `win_cnt` counts 0..WINDOW-1 and wraps to 0.
  - On the wrap cycle, `coinc_cnt` is loaded with `coinc ? 1 : 0`. A coincidence on the wrap cycle belongs to the new window.
  - Otherwise `coinc_cnt` increments on `coinc` and saturates.
- **Threshold event.** `thr_hit` is true when the next value of `coinc_cnt` equals `COINC_THRESH`. It fires once per window, at the crossing only.
- **Trigger count.** `total_trig` increments on `trig_rise` and saturates at 255. `ack` does not clear it; only reset does.
- **FSM transitions:**
  - IDLE -> WATCH on `coinc` without `thr_hit`.
  - IDLE or WATCH -> ALARM on `thr_hit` or `trig_rise`.
  - WATCH -> IDLE on a window wrap that has no coincidence in that cycle.
  - ALARM -> IDLE on `ack`, unless an alarm event occurs in the same cycle.
- **Alarm and cause.** `alarm = (state == ALARM)`.
  - On entry to ALARM, `cause` is loaded with the event bits `{trig_rise, thr_hit}`.
  - While in ALARM, new events OR into `cause`.
- **Counting in ALARM.** Window counting and trigger counting continue while in ALARM.
- **Acknowledge in ALARM:**
  - Plain `ack`: `cause` <= 0, `coinc_cnt` <= 0, `win_cnt` <= 0, state <= IDLE.
  - `ack` coincident with a new event: the event wins. State stays ALARM, `cause` <= the new event bits only (old bits dropped), and `coinc_cnt`/`win_cnt` are cleared as for a plain ack. The bench can therefore distinguish a re-fire from a stale alarm.
- **`ack` outside ALARM** is ignored.
- **Reset.** `rst` low at a rising edge clears every register, including sample registers, regardless of state. All outputs read 0 in the cycle after. Reset asserted mid-alarm discards `cause` and both counts.

## Timing
- Input level present in cycle n is sampled at edge n+1. FSM and counters react at edge n+2.
- Latency from the input to `alarm` is 2 cycles.
- `trig_rise` needs `trigger` low in cycle n-1 and high in cycle n. `alarm` is then high from cycle n+2.
- The crossing coincidence sampled in cycle n gives `coinc_cnt == COINC_THRESH` and `alarm` in the same cycle, n+2.
- `ack` sampled at edge k gives `alarm` low from cycle k+1.
- All outputs are registered, with no combinational input-to-output path.
- Reset values: `alarm` 0, `cause` 0, `coinc_cnt` 0, `total_trig` 0, `state` 0.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `r1`=`r2`=`trigger`=1. Every output stays 0 and `state`=0. Release `rst`; `trigger` held high without a low phase yields `trig_rise` only if `trig_qq` was 0, so expect `total_trig`=1 and `alarm` 2 cycles after release.
- **Threshold:** `COINC_THRESH`=4, `WINDOW`=16. Drive 4 coincidence cycles spaced 2 apart inside one window. `alarm`=1, `cause`=01, `coinc_cnt`=4, all 2 cycles after the 4th sample.
- **Window wrap:** same parameters. 3 coincidences, then idle past the wrap, then 3 more. No alarm. `coinc_cnt` reads 3, then 0 after the wrap (with `state` back to IDLE), then 3.
- **Trigger edge vs level:** raise `trigger` and hold it for 5 cycles. `alarm`=1, `cause`=10, `total_trig`=1 (not 5).
- **Ack collision:** in ALARM with `cause`=10, pulse `ack` in the cycle a `thr_hit` is evaluated. `alarm` stays 1, `cause`=01, `coinc_cnt`=0.
- **Saturation:** 300 `trigger` pulses. `total_trig`=255 and no wrap to 0. `COINC_THRESH`=2^CNT_W-1 with every cycle coincident in a long window gives `coinc_cnt` holding at all-ones.
